// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_OVS     = 16;
  localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with OVS-times oversampling: samples each bit at its midpoint
// and presents the assembled byte with a one-clock done strobe.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int OVS     = DEF_OVS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reciever,
  input  logic            s_tick,
  output logic            r_done_tick,
  output logic [DBIT-1:0] data_out
);

  localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  uart_state_t     state, state_n;
  logic [S_W-1:0]  s, s_n;
  logic [N_W-1:0]  n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic [DBIT-1:0] data_n;
  logic            done_n;
  logic            rx_p0, rx_p1;
  logic            rx;

  // Stage p0/p1: two-flop synchroniser; reset to the idle-high line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= reciever;
      rx_p1 <= rx_p0;
    end
  end

  assign rx = rx_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      s           <= '0;
      n           <= '0;
      b           <= '0;
      data_out    <= '0;
      r_done_tick <= 1'b0;
    end else begin
      state       <= state_n;
      s           <= s_n;
      n           <= n_n;
      b           <= b_n;
      data_out    <= data_n;
      r_done_tick <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    data_n  = data_out;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          // Half a bit in: confirm the start bit is still low, else treat as a glitch
          if (s == S_W'(OVS / 2 - 1)) begin
            if (!rx) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_W'(OVS - 1)) begin
            b_n = {rx, b[DBIT-1:1]};
            s_n = '0;
            if (n == N_W'(DBIT - 1)) state_n = STOP;
            else                     n_n     = n + N_W'(1);
          end else begin
            s_n = s + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          // Stop level is deliberately not checked; the byte is delivered regardless
          if (s == S_W'(SB_TICK - 1)) begin
            data_n  = b;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s + S_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are serialised at 256 clk per bit and
// every done strobe is matched against the byte queued when its frame was driven.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int BIT = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       reciever;
  logic       s_tick;
  logic       r_done_tick;
  logic [7:0] data_out;

  int         checks   = 0;
  int         failures = 0;
  int         pulses   = 0;
  logic [7:0] q[$];
  longint     edge_t;
  longint     last_done_t;

  uart_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .reciever   (reciever),
    .s_tick     (s_tick),
    .r_done_tick(r_done_tick),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops one expected byte per strobe and checks the strobe is one clock wide
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_one_clk", {31'd0, r_done_tick}, 32'd0);
      if (r_done_tick === 1'b1) begin
        pulses++;
        last_done_t = $time;
        if (q.size() == 0) chk("spurious_done", q.size(), 32'd1);
        else               chk("rx_byte", {24'd0, data_out}, {24'd0, q.pop_front()});
      end
      prev_done = (r_done_tick === 1'b1);
    end
  end

  task automatic idle_bits(input int nbits);
    reciever = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  // stop_low keeps the stop bit low through its sample point, then releases the line
  task automatic send_frame(input logic [7:0] d, input bit stop_low);
    q.push_back(d);
    reciever = 1'b0;
    edge_t   = $time;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      reciever = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_low) begin
      reciever = 1'b0;
      repeat (BIT * 3 / 4) @(negedge clk);
      reciever = 1'b1;
      repeat (BIT / 4) @(negedge clk);
    end else begin
      reciever = 1'b1;
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    int p0;
    longint lat;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    reciever = 1'b1;
    reset    = 1'b1;
    #2 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_data", {24'd0, data_out}, 32'h00);
    chk("reset_done", {31'd0, r_done_tick}, 32'd0);
    reset = 1'b1;
    idle_bits(2);
    chk("idle_no_pulse", pulses, 32'd0);
    chk("idle_data", {24'd0, data_out}, 32'h00);

    p0 = pulses;
    send_frame(8'h48, 1'b0);
    wait_drain(4 * BIT);
    idle_bits(1);
    chk("single_pulses", pulses - p0, 32'd1);
    lat = (last_done_t - edge_t) / 10;
    chk("single_latency_ok", {31'd0, (lat >= 2400 && lat <= 2460)}, 32'd1);

    p0 = pulses;
    foreach (hello[i]) send_frame(hello[i], 1'b0);
    wait_drain(4 * BIT);
    idle_bits(1);
    chk("stream_pulses", pulses - p0, 32'd5);

    p0 = pulses;
    reciever = 1'b0;
    repeat (48) @(negedge clk);
    idle_bits(3);
    chk("glitch_no_pulse", pulses - p0, 32'd0);
    chk("glitch_data_hold", {24'd0, data_out}, 32'h4F);

    p0 = pulses;
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    chk("framing_drained", q.size(), 32'd0);
    send_frame(8'h3C, 1'b0);
    wait_drain(4 * BIT);
    idle_bits(1);
    chk("framing_pulses", pulses - p0, 32'd2);

    p0 = pulses;
    reciever = 1'b0;
    repeat (BIT) @(negedge clk);
    reciever = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_data", {24'd0, data_out}, 32'h00);
    chk("midreset_done", {31'd0, r_done_tick}, 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    idle_bits(12);
    chk("midreset_no_pulse", pulses - p0, 32'd0);
    send_frame(8'h55, 1'b0);
    wait_drain(4 * BIT);
    idle_bits(1);

    p0 = pulses;
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    wait_drain(4 * BIT);
    idle_bits(12);
    chk("pattern_pulses", pulses - p0, 32'd2);
    chk("final_data", {24'd0, data_out}, 32'hFF);
    chk("total_pulses", pulses, 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
